// File: rtl/fixed_point_arith_unit.sv
// -----------------------------------------------------------------------------
// fixed_point_arith_unit
//   Multi-cycle fixed-point arithmetic unit for the FPU path. Operands are
//   two's-complement Q(WIDTH-FBITS).FBITS; SQRT treats its radicand as unsigned.
//   ADD/SUB complete in one cycle, MUL iterates over MUL_SLICE x MUL_SLICE
//   partial products ((WIDTH/MUL_SLICE)^2 cycles), SQRT is a bit-pair restoring
//   integer root ((WIDTH+FBITS)/2 cycles).
//
//   Build option: define FXP_SATURATE_EN to clamp signed overflow of ADD/SUB/MUL
//   to the most positive/negative value and flag it on 'overflow'. Without it,
//   results wrap and 'overflow' stays 0. Latency is the same in both builds.
//
// Ports
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   start      in   request, sampled only while busy=0
//   operation  in   2'd0 ADD, 2'd1 SUB, 2'd2 MUL, 2'd3 SQRT
//   operand_1  in   first operand / SQRT radicand
//   operand_2  in   second operand (ignored for SQRT)
//   result     out  registered result, held until the next completion
//   ready      out  one-cycle completion pulse
//   busy       out  MUL/SQRT in flight
//   overflow   out  result saturated (valid with ready)
//   invalid    out  SQRT of a negative operand (valid with ready)
// -----------------------------------------------------------------------------
module fixed_point_arith_unit #(
  parameter int WIDTH     = 32,
  parameter int FBITS     = 10,
  parameter int MUL_SLICE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       operation,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             busy,
  output logic             overflow,
  output logic             invalid
);

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_SQRT = 2'd3;

  localparam int N  = WIDTH / MUL_SLICE;
  localparam int K  = (WIDTH + FBITS) / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(K) + 1;

  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SAT_MAX = ~SAT_MIN;

`ifdef FXP_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_SQRT = 2'd2
  } state_t;

  // Clamp value for a saturated result of the given sign.
  function automatic logic [WIDTH-1:0] sat_value(input logic neg);
    sat_value = neg ? SAT_MIN : SAT_MAX;
  endfunction

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_d;
  logic                 inv_q, inv_d;

  logic [WIDTH-1:0]     a_mag_q, a_mag_d;
  logic [WIDTH-1:0]     b_mag_q, b_mag_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [IW-1:0]        i_q, i_d;
  logic [IW-1:0]        j_q, j_d;

  logic [2*K-1:0]       rad_q, rad_d;
  logic [K+1:0]         rem_q, rem_d;
  logic [K-1:0]         root_q, root_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  // ADD/SUB: evaluated directly on the request-cycle operands.
  logic [WIDTH-1:0] add_sum_s, sub_diff_s;
  logic             add_ovf_s, sub_ovf_s;

  assign add_sum_s  = operand_1 + operand_2;
  assign sub_diff_s = operand_1 - operand_2;
  assign add_ovf_s  = SAT_EN && (operand_1[WIDTH-1] == operand_2[WIDTH-1])
                             && (add_sum_s[WIDTH-1] != operand_1[WIDTH-1]);
  assign sub_ovf_s  = SAT_EN && (operand_1[WIDTH-1] != operand_2[WIDTH-1])
                             && (sub_diff_s[WIDTH-1] != operand_1[WIDTH-1]);

  // MUL datapath: one slice product per cycle, placed at its (i+j) slice offset.
  logic [MUL_SLICE-1:0]   a_sl_s, b_sl_s;
  logic [2*MUL_SLICE-1:0] pp_s;
  logic [2*WIDTH-1:0]     pp_ext_s, acc_sum_s;
  logic [WIDTH-1:0]       mag_res_s, mul_wrap_s;
  logic                   mul_ovf_s, mul_last_s;

  assign a_sl_s     = a_mag_q[int'(i_q)*MUL_SLICE +: MUL_SLICE];
  assign b_sl_s     = b_mag_q[int'(j_q)*MUL_SLICE +: MUL_SLICE];
  assign pp_s       = {{MUL_SLICE{1'b0}}, a_sl_s} * {{MUL_SLICE{1'b0}}, b_sl_s};
  assign acc_sum_s  = acc_q + (pp_ext_s << ((int'(i_q) + int'(j_q)) * MUL_SLICE));
  assign mag_res_s  = acc_sum_s[WIDTH+FBITS-1:FBITS];
  assign mul_wrap_s = neg_q ? -mag_res_s : mag_res_s;
  assign mul_last_s = (i_q == IW'(N-1)) && (j_q == IW'(N-1));

  // A negative result may reach exactly 2^(WIDTH-1); a positive one may not.
  assign mul_ovf_s  = SAT_EN && ((|acc_sum_s[2*WIDTH-1:WIDTH+FBITS]) ||
                      (neg_q ? (mag_res_s[WIDTH-1] && (|mag_res_s[WIDTH-2:0]))
                             : mag_res_s[WIDTH-1]));

  // Zero-extend the slice product to accumulator width.
  always_comb begin
    pp_ext_s                    = '0;
    pp_ext_s[2*MUL_SLICE-1:0]   = pp_s;
  end

  // SQRT datapath: bring down the next radicand bit pair and try (4*root + 1).
  logic [K+1:0] rem_shift_s, trial_s, rem_next_s;
  logic [K-1:0] root_next_s;
  logic         sq_ge_s;

  assign rem_shift_s = {rem_q[K-1:0], rad_q[2*K-1:2*K-2]};
  assign trial_s     = {root_q, 2'b01};
  assign sq_ge_s     = (rem_shift_s >= trial_s);
  assign rem_next_s  = sq_ge_s ? (rem_shift_s - trial_s) : rem_shift_s;
  assign root_next_s = {root_q[K-2:0], sq_ge_s};

  // Fraction bits below the result and the remainder's headroom bits are
  // never needed after the final step.
  logic unused_s;
  assign unused_s = ^{acc_sum_s[FBITS-1:0], rem_q[K+1:K]};

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ready_d  = 1'b0;
    ovf_d    = ovf_q;
    inv_d    = inv_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    i_d      = i_q;
    j_d      = j_q;
    rad_d    = rad_q;
    rem_d    = rem_q;
    root_d   = root_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (operation)
            OP_ADD: begin
              result_d = add_ovf_s ? sat_value(operand_1[WIDTH-1]) : add_sum_s;
              ovf_d    = add_ovf_s;
              inv_d    = 1'b0;
              ready_d  = 1'b1;
            end
            OP_SUB: begin
              result_d = sub_ovf_s ? sat_value(operand_1[WIDTH-1]) : sub_diff_s;
              ovf_d    = sub_ovf_s;
              inv_d    = 1'b0;
              ready_d  = 1'b1;
            end
            OP_MUL: begin
              // Magnitudes as WIDTH-bit unsigned: the most negative value is exact.
              a_mag_d = operand_1[WIDTH-1] ? -operand_1 : operand_1;
              b_mag_d = operand_2[WIDTH-1] ? -operand_2 : operand_2;
              neg_d   = operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
              acc_d   = '0;
              i_d     = '0;
              j_d     = '0;
              state_d = ST_MUL;
            end
            OP_SQRT: begin
              if (operand_1[WIDTH-1]) begin
                result_d = '0;
                ovf_d    = 1'b0;
                inv_d    = 1'b1;
                ready_d  = 1'b1;
              end else begin
                rad_d   = {operand_1, {FBITS{1'b0}}};
                rem_d   = '0;
                root_d  = '0;
                cnt_d   = CW'(K-1);
                state_d = ST_SQRT;
              end
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_MUL: begin
        acc_d = acc_sum_s;
        if (mul_last_s) begin
          result_d = mul_ovf_s ? sat_value(neg_q) : mul_wrap_s;
          ovf_d    = mul_ovf_s;
          inv_d    = 1'b0;
          ready_d  = 1'b1;
          state_d  = ST_IDLE;
        end else if (j_q == IW'(N-1)) begin
          j_d = '0;
          i_d = i_q + IW'(1);
        end else begin
          j_d = j_q + IW'(1);
        end
      end

      ST_SQRT: begin
        rad_d  = {rad_q[2*K-3:0], 2'b00};
        rem_d  = rem_next_s;
        root_d = root_next_s;
        if (cnt_q == '0) begin
          result_d = WIDTH'(root_next_s);
          ovf_d    = 1'b0;
          inv_d    = 1'b0;
          ready_d  = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      inv_q    <= inv_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      i_q      <= i_d;
      j_q      <= j_d;
      rad_q    <= rad_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result   = result_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign invalid  = inv_q;

endmodule

// File: doc/fixed_point_arith_unit.md
Name: fixed_point_arith_unit

Overview:
Parametrised multi-cycle fixed-point arithmetic unit for the core's FPU path, in unsigned/two's-complement Q(WIDTH-FBITS).FBITS format.
- Executes ADD, SUB, signed MUL and unsigned SQRT.
- Explicit start/busy/ready handshake; every op completes with a registered single-cycle ready pulse.
- MUL is iterative over MUL_SLICE-wide partial products, so area/latency is tunable.

Parameters:
WIDTH, 32, operand/result width; WIDTH+FBITS must be even.
FBITS, 10, fractional bits.
MUL_SLICE, 16, slice width of the internal unsigned multiplier; WIDTH must be a multiple of it. N = WIDTH/MUL_SLICE.

Ports:
clk  input  1  clock.
reset  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
operation  input  2  FPU_ADD, FPU_SUB, FPU_MUL, FPU_SQRT encodings from Defines.vh.
operand_1  input  WIDTH  first operand, or radicand for SQRT.
operand_2  input  WIDTH  second operand; ignored for SQRT.
result  output  WIDTH  registered result; held until the next completion.
ready  output  1  one-cycle completion pulse.
busy  output  1  operation in flight.
overflow  output  1  result saturated; valid with ready.
invalid  output  1  SQRT of a negative operand; valid with ready.

Behaviour:
- Reset (async): result=0, ready=0, busy=0, overflow=0, invalid=0, FSM=IDLE, all datapath registers cleared.
- Reset mid-operation aborts the op; no ready pulse is produced.
- FSM states: IDLE, MUL, SQRT.
- Accept: start=1 with busy=0 in cycle T. Operands and operation are latched at T. start while busy=1 is ignored.
- ready cycle: busy=0, so a new start is accepted in that same cycle.
- ADD/SUB: two's-complement, computed at T. FSM stays IDLE. ready at T+1. busy is never asserted.
- MUL:
  - IDLE->MUL. Signs are stripped and magnitudes latched.
  - One MUL_SLICE x MUL_SLICE partial product per cycle, N^2 cycles, shift-accumulated into a 2*WIDTH accumulator.
  - Magnitude is negated if the operand signs differ.
  - result = acc[WIDTH+FBITS-1:FBITS], truncated toward zero on the magnitude.
  - ready at T+N^2+1, then MUL->IDLE.
- SQRT:
  - If operand_1[WIDTH-1]=1: result=0, invalid=1, ready at T+1, FSM stays IDLE.
  - Otherwise IDLE->SQRT. Radicand = {operand_1, FBITS'b0}.
  - Bit-pair restoring integer square root, one bit per cycle, (WIDTH+FBITS)/2 iterations.
  - result = floor root, zero-extended to WIDTH.
  - ready at T+(WIDTH+FBITS)/2+1, then SQRT->IDLE.
- busy is high from T+1 through the cycle before ready, for MUL and SQRT only.
- overflow and invalid are registered with result, and are cleared on every completion that does not set them.
- Operand 0 for MUL or SQRT gives result 0 with full latency; there is no early exit.
- Most-negative operand in MUL: the magnitude is computed as WIDTH-bit unsigned, so it is exact.

Optional Feature:
FXP_SATURATE_EN
- Defined:
  - ADD/SUB signed overflow clamps to 0x7FF..F or 0x800..0 and sets overflow.
  - MUL clamps the same way when any discarded upper product bit, or the sign, is inconsistent, and sets overflow.
- Undefined: results wrap (low WIDTH bits) and overflow is tied 0.
- Latency is identical in both builds.

Test Plan:
All cases use WIDTH=32, FBITS=10, MUL_SLICE=16.
1. ADD 0x600 + 0x800 (1.5+2.0) at T -> ready at T+1, result 0x00000E00, busy stays 0. SUB 0x600 - 0x800 -> 0xFFFFFE00.
2. MUL 0x600 * 0x800 -> busy T+1..T+4, ready at T+5, result 0x00000C00. MUL 0xFFFFFA00 * 0x800 -> 0xFFFFF400.
3. SQRT 0x1000 (4.0) -> ready at T+22, result 0x800. SQRT 0x800 (2.0) -> 0x5A8. SQRT 0x80000000 -> ready T+1, result 0, invalid=1.
4. ADD 0x7FFFFFFF + 0x400:
   - With FXP_SATURATE_EN: result 0x7FFFFFFF, overflow=1.
   - Without: result 0x800003FF, overflow=0.
   - MUL 0x7FFFFC00 * 0x800 with FXP_SATURATE_EN: result 0x7FFFFFFF, overflow=1.
5. start pulsed at T+3 of a MUL -> ignored, single ready at T+5. Second start in the ready cycle -> accepted, next ready at T+10.
6. reset asserted at T+10 of a SQRT -> all outputs 0 immediately, no ready. Fresh ADD after release completes normally.
